// File: rtl/integer_issue_queue.sv
// ============================================================================
// integer_issue_queue
//
// Collapsing, age-ordered issue queue for integer micro-ops. Up to two
// entries are enqueued per cycle. Source operands are woken by a write-back
// tag broadcast. The oldest entry with both operands ready is offered for
// issue. When an entry issues, every younger entry slides down one slot, so
// entry 0 is always the oldest.
//
// Optional feature macro: IQ_STATS_EN
//   When defined, adds saturating 32-bit counters for issued entries and for
//   cycles in which the queue could not accept a pair.
//
// Ports
//   clk, rst_n                   clock (rising edge), async active-low reset
//   i_valid[1:0]                 per-slot enqueue request, slot 0 is older
//   i_phys_rs/i_phys_rt          per-slot source tags (2 x PREG_W, slot 0 low)
//   i_uses_rs/i_uses_rt          per-slot source-used flags
//   i_rs_ready/i_rt_ready        per-slot source ready at enqueue
//   i_al_id                      per-slot active-list id (2 x AL_W)
//   i_payload                    per-slot opaque payload (2 x PAY_W)
//   o_ready                      queue can take two entries this cycle
//   wb_valid, wb_uses_rw, wb_tag write-back broadcast
//   flush                        discard every entry
//   o_valid, i_issue_ready       issue handshake
//   o_phys_rs/o_phys_rt/o_al_id/o_payload  selected entry, zero when idle
//   o_stat_issued, o_stat_full   statistics (IQ_STATS_EN only)
// ============================================================================
module integer_issue_queue #(
    parameter int DEPTH  = 8,
    parameter int PREG_W = 6,
    parameter int AL_W   = 5,
    parameter int PAY_W  = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          i_valid,
    input  logic [2*PREG_W-1:0] i_phys_rs,
    input  logic [2*PREG_W-1:0] i_phys_rt,
    input  logic [1:0]          i_uses_rs,
    input  logic [1:0]          i_uses_rt,
    input  logic [1:0]          i_rs_ready,
    input  logic [1:0]          i_rt_ready,
    input  logic [2*AL_W-1:0]   i_al_id,
    input  logic [2*PAY_W-1:0]  i_payload,
    output logic                o_ready,
    input  logic                wb_valid,
    input  logic                wb_uses_rw,
    input  logic [PREG_W-1:0]   wb_tag,
    input  logic                flush,
    output logic                o_valid,
    input  logic                i_issue_ready,
    output logic [PREG_W-1:0]   o_phys_rs,
    output logic [PREG_W-1:0]   o_phys_rt,
    output logic [AL_W-1:0]     o_al_id,
    output logic [PAY_W-1:0]    o_payload
`ifdef IQ_STATS_EN
    ,
    output logic [31:0]         o_stat_issued,
    output logic [31:0]         o_stat_full
`endif
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    logic              entValid_q   [DEPTH];
    logic [PREG_W-1:0] entRsTag_q   [DEPTH];
    logic [PREG_W-1:0] entRtTag_q   [DEPTH];
    logic              entUsesRs_q  [DEPTH];
    logic              entUsesRt_q  [DEPTH];
    logic              entRsRdy_q   [DEPTH];
    logic              entRtRdy_q   [DEPTH];
    logic [AL_W-1:0]   entAlId_q    [DEPTH];
    logic [PAY_W-1:0]  entPayload_q [DEPTH];
    logic [CNT_W-1:0]  count_q;

    logic              entValid_d   [DEPTH];
    logic [PREG_W-1:0] entRsTag_d   [DEPTH];
    logic [PREG_W-1:0] entRtTag_d   [DEPTH];
    logic              entUsesRs_d  [DEPTH];
    logic              entUsesRt_d  [DEPTH];
    logic              entRsRdy_d   [DEPTH];
    logic              entRtRdy_d   [DEPTH];
    logic [AL_W-1:0]   entAlId_d    [DEPTH];
    logic [PAY_W-1:0]  entPayload_d [DEPTH];
    logic [CNT_W-1:0]  count_d;

    logic              wbHit;
    logic              wkRsRdy [DEPTH];
    logic              wkRtRdy [DEPTH];

    logic [PREG_W-1:0] inRsTag   [2];
    logic [PREG_W-1:0] inRtTag   [2];
    logic              inRsRdy   [2];
    logic              inRtRdy   [2];
    logic [AL_W-1:0]   inAlId    [2];
    logic [PAY_W-1:0]  inPayload [2];

    logic              selFound;
    logic [IDX_W-1:0]  selIdx;
    logic              issueFire;
    logic              enqFire;
    logic              bothValid;
    logic              firstSlot;
    logic [CNT_W-1:0]  baseCount;
    logic [IDX_W-1:0]  wrIdx0;
    logic [IDX_W-1:0]  wrIdx1;

    assign wbHit     = wb_valid & wb_uses_rw;
    assign o_ready   = (count_q <= CNT_W'(DEPTH - 2));
    assign enqFire   = o_ready & (|i_valid);
    assign bothValid = &i_valid;
    // A lone slot-1 request is treated as if it had arrived on slot 0.
    assign firstSlot = ~i_valid[0];
    assign issueFire = selFound & i_issue_ready;
    // Appends land after the collapse, so the write position is computed
    // from the occupancy that remains once the issuing entry is gone.
    assign baseCount = count_q - CNT_W'(issueFire);
    assign wrIdx0    = baseCount[IDX_W-1:0];
    assign wrIdx1    = wrIdx0 + IDX_W'(1);

    // Unpack the two enqueue slots. An incoming operand whose tag matches a
    // broadcast in the same cycle is written already ready, so that a
    // producer finishing this cycle cannot be missed.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            inRsTag[s]   = i_phys_rs[s*PREG_W +: PREG_W];
            inRtTag[s]   = i_phys_rt[s*PREG_W +: PREG_W];
            inAlId[s]    = i_al_id[s*AL_W +: AL_W];
            inPayload[s] = i_payload[s*PAY_W +: PAY_W];
            inRsRdy[s]   = i_rs_ready[s] |
                           (wbHit & i_uses_rs[s] & (inRsTag[s] == wb_tag));
            inRtRdy[s]   = i_rt_ready[s] |
                           (wbHit & i_uses_rt[s] & (inRtTag[s] == wb_tag));
        end
    end

    // Wakeup of stored entries. The result only feeds next state, never the
    // select logic, so a broadcast makes an entry eligible one cycle later.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            wkRsRdy[i] = entRsRdy_q[i] |
                         (wbHit & entUsesRs_q[i] & (entRsTag_q[i] == wb_tag));
            wkRtRdy[i] = entRtRdy_q[i] |
                         (wbHit & entUsesRt_q[i] & (entRtTag_q[i] == wb_tag));
        end
    end

    // Oldest-first select: the lowest valid index with both operands usable
    // (either not used or already ready) wins.
    always_comb begin
        selFound = 1'b0;
        selIdx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!selFound && entValid_q[i] &&
                (!entUsesRs_q[i] || entRsRdy_q[i]) &&
                (!entUsesRt_q[i] || entRtRdy_q[i])) begin
                selFound = 1'b1;
                selIdx   = IDX_W'(i);
            end
        end
    end

    // Issue outputs come straight from the registered entry, forced to zero
    // when nothing is selectable so that downstream never sees stale data.
    always_comb begin
        o_valid   = selFound;
        o_phys_rs = '0;
        o_phys_rt = '0;
        o_al_id   = '0;
        o_payload = '0;
        if (selFound) begin
            o_phys_rs = entRsTag_q[selIdx];
            o_phys_rt = entRtTag_q[selIdx];
            o_al_id   = entAlId_q[selIdx];
            o_payload = entPayload_q[selIdx];
        end
    end

    // Next-state for the array. The order is: collapse over the issuing
    // entry, then append the new entries, then let flush override all of
    // it. The top slot has nothing above it, so it empties when a collapse
    // passes through it.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entValid_d[i]   = entValid_q[i];
            entRsTag_d[i]   = entRsTag_q[i];
            entRtTag_d[i]   = entRtTag_q[i];
            entUsesRs_d[i]  = entUsesRs_q[i];
            entUsesRt_d[i]  = entUsesRt_q[i];
            entRsRdy_d[i]   = wkRsRdy[i];
            entRtRdy_d[i]   = wkRtRdy[i];
            entAlId_d[i]    = entAlId_q[i];
            entPayload_d[i] = entPayload_q[i];
            if (issueFire && (IDX_W'(i) >= selIdx)) begin
                if (i == DEPTH - 1) begin
                    entValid_d[i] = 1'b0;
                    entRsRdy_d[i] = 1'b0;
                    entRtRdy_d[i] = 1'b0;
                end else begin
                    entValid_d[i]   = entValid_q[(i + 1) % DEPTH];
                    entRsTag_d[i]   = entRsTag_q[(i + 1) % DEPTH];
                    entRtTag_d[i]   = entRtTag_q[(i + 1) % DEPTH];
                    entUsesRs_d[i]  = entUsesRs_q[(i + 1) % DEPTH];
                    entUsesRt_d[i]  = entUsesRt_q[(i + 1) % DEPTH];
                    entRsRdy_d[i]   = wkRsRdy[(i + 1) % DEPTH];
                    entRtRdy_d[i]   = wkRtRdy[(i + 1) % DEPTH];
                    entAlId_d[i]    = entAlId_q[(i + 1) % DEPTH];
                    entPayload_d[i] = entPayload_q[(i + 1) % DEPTH];
                end
            end
        end

        count_d = baseCount;

        if (enqFire) begin
            entValid_d[wrIdx0]   = 1'b1;
            entRsTag_d[wrIdx0]   = inRsTag[firstSlot];
            entRtTag_d[wrIdx0]   = inRtTag[firstSlot];
            entUsesRs_d[wrIdx0]  = i_uses_rs[firstSlot];
            entUsesRt_d[wrIdx0]  = i_uses_rt[firstSlot];
            entRsRdy_d[wrIdx0]   = inRsRdy[firstSlot];
            entRtRdy_d[wrIdx0]   = inRtRdy[firstSlot];
            entAlId_d[wrIdx0]    = inAlId[firstSlot];
            entPayload_d[wrIdx0] = inPayload[firstSlot];
            if (bothValid) begin
                entValid_d[wrIdx1]   = 1'b1;
                entRsTag_d[wrIdx1]   = inRsTag[1];
                entRtTag_d[wrIdx1]   = inRtTag[1];
                entUsesRs_d[wrIdx1]  = i_uses_rs[1];
                entUsesRt_d[wrIdx1]  = i_uses_rt[1];
                entRsRdy_d[wrIdx1]   = inRsRdy[1];
                entRtRdy_d[wrIdx1]   = inRtRdy[1];
                entAlId_d[wrIdx1]    = inAlId[1];
                entPayload_d[wrIdx1] = inPayload[1];
            end
            count_d = baseCount + (bothValid ? CNT_W'(2) : CNT_W'(1));
        end

        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entValid_d[i] = 1'b0;
                entRsRdy_d[i] = 1'b0;
                entRtRdy_d[i] = 1'b0;
            end
            count_d = '0;
        end
    end

    // State registers. Reset empties the queue immediately, without
    // waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entValid_q[i]   <= 1'b0;
                entRsTag_q[i]   <= '0;
                entRtTag_q[i]   <= '0;
                entUsesRs_q[i]  <= 1'b0;
                entUsesRt_q[i]  <= 1'b0;
                entRsRdy_q[i]   <= 1'b0;
                entRtRdy_q[i]   <= 1'b0;
                entAlId_q[i]    <= '0;
                entPayload_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entValid_q[i]   <= entValid_d[i];
                entRsTag_q[i]   <= entRsTag_d[i];
                entRtTag_q[i]   <= entRtTag_d[i];
                entUsesRs_q[i]  <= entUsesRs_d[i];
                entUsesRt_q[i]  <= entUsesRt_d[i];
                entRsRdy_q[i]   <= entRsRdy_d[i];
                entRtRdy_q[i]   <= entRtRdy_d[i];
                entAlId_q[i]    <= entAlId_d[i];
                entPayload_q[i] <= entPayload_d[i];
            end
            count_q <= count_d;
        end
    end

`ifdef IQ_STATS_EN
    logic [31:0] statIssued_q;
    logic [31:0] statFull_q;

    // Saturating statistics. They survive a flush so that mispredict
    // recovery does not hide activity. An issue handshake that coincides
    // with a flush is not counted, because the flush wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            statIssued_q <= '0;
            statFull_q   <= '0;
        end else begin
            if (issueFire && !flush && (statIssued_q != '1)) begin
                statIssued_q <= statIssued_q + 32'd1;
            end
            if (!o_ready && (statFull_q != '1)) begin
                statFull_q <= statFull_q + 32'd1;
            end
        end
    end

    assign o_stat_issued = statIssued_q;
    assign o_stat_full   = statFull_q;
`endif

endmodule

// File: tb/tb_integer_issue_queue.sv
// ============================================================================
// tb_integer_issue_queue
//
// Self-checking bench for integer_issue_queue. A queue-based reference
// model holds the age-ordered entries. Each cycle it predicts the selected
// entry and the ready flag, then applies issue, wakeup and enqueue.
// Directed scenarios cover the main behaviours. A randomized run follows.
// ============================================================================
module tb_integer_issue_queue;

    localparam int DEPTH  = 8;
    localparam int PREG_W = 6;
    localparam int AL_W   = 5;
    localparam int PAY_W  = 64;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [1:0]          i_valid;
    logic [2*PREG_W-1:0] i_phys_rs;
    logic [2*PREG_W-1:0] i_phys_rt;
    logic [1:0]          i_uses_rs;
    logic [1:0]          i_uses_rt;
    logic [1:0]          i_rs_ready;
    logic [1:0]          i_rt_ready;
    logic [2*AL_W-1:0]   i_al_id;
    logic [2*PAY_W-1:0]  i_payload;
    logic                o_ready;
    logic                wb_valid;
    logic                wb_uses_rw;
    logic [PREG_W-1:0]   wb_tag;
    logic                flush;
    logic                o_valid;
    logic                i_issue_ready;
    logic [PREG_W-1:0]   o_phys_rs;
    logic [PREG_W-1:0]   o_phys_rt;
    logic [AL_W-1:0]     o_al_id;
    logic [PAY_W-1:0]    o_payload;
`ifdef IQ_STATS_EN
    logic [31:0]         o_stat_issued;
    logic [31:0]         o_stat_full;
`endif

    always #5 clk = ~clk;

    integer_issue_queue #(
        .DEPTH(DEPTH), .PREG_W(PREG_W), .AL_W(AL_W), .PAY_W(PAY_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_valid(i_valid), .i_phys_rs(i_phys_rs), .i_phys_rt(i_phys_rt),
        .i_uses_rs(i_uses_rs), .i_uses_rt(i_uses_rt),
        .i_rs_ready(i_rs_ready), .i_rt_ready(i_rt_ready),
        .i_al_id(i_al_id), .i_payload(i_payload), .o_ready(o_ready),
        .wb_valid(wb_valid), .wb_uses_rw(wb_uses_rw), .wb_tag(wb_tag),
        .flush(flush), .o_valid(o_valid), .i_issue_ready(i_issue_ready),
        .o_phys_rs(o_phys_rs), .o_phys_rt(o_phys_rt),
        .o_al_id(o_al_id), .o_payload(o_payload)
`ifdef IQ_STATS_EN
        , .o_stat_issued(o_stat_issued), .o_stat_full(o_stat_full)
`endif
    );

    typedef struct packed {
        logic [PREG_W-1:0] rs;
        logic [PREG_W-1:0] rt;
        logic              usesRs;
        logic              usesRt;
        logic              rsRdy;
        logic              rtRdy;
        logic [AL_W-1:0]   al;
        logic [PAY_W-1:0]  pay;
    } entry_t;

    entry_t            mq[$];
    int                compared   = 0;
    int                mismatched = 0;
    logic [31:0]       statIssued = 0;
    logic [31:0]       statFull   = 0;
    logic              expValid;
    logic              expReady;
    int                expSel;
    logic [PREG_W-1:0] expRs;
    logic [PREG_W-1:0] expRt;
    logic [AL_W-1:0]   expAl;
    logic [PAY_W-1:0]  expPay;

    // An operand can be consumed if it is not used or it is already ready.
    function automatic bit opsReady(input entry_t e);
        return (!e.usesRs || e.rsRdy) && (!e.usesRt || e.rtRdy);
    endfunction

    // Predict what the queue should show during the current cycle.
    function automatic void modelPredict();
        expValid = 1'b0; expSel = -1;
        expRs = '0; expRt = '0; expAl = '0; expPay = '0;
        for (int i = 0; i < mq.size(); i++) begin
            if (opsReady(mq[i])) begin
                expValid = 1'b1; expSel = i;
                expRs = mq[i].rs; expRt = mq[i].rt;
                expAl = mq[i].al; expPay = mq[i].pay;
                break;
            end
        end
        expReady = (mq.size() <= DEPTH - 2);
    endfunction

    // Apply the current inputs to the model as the next clock edge would.
    function automatic void modelAdvance();
        entry_t e;
        modelPredict();
        if (!expReady && statFull != 32'hFFFF_FFFF) statFull = statFull + 1;
        if (flush) begin
            mq.delete();
            return;
        end
        if (expValid && i_issue_ready) begin
            mq.delete(expSel);
            if (statIssued != 32'hFFFF_FFFF) statIssued = statIssued + 1;
        end
        if (wb_valid && wb_uses_rw) begin
            for (int i = 0; i < mq.size(); i++) begin
                if (mq[i].usesRs && mq[i].rs == wb_tag) mq[i].rsRdy = 1'b1;
                if (mq[i].usesRt && mq[i].rt == wb_tag) mq[i].rtRdy = 1'b1;
            end
        end
        if (expReady && (i_valid != 2'b00)) begin
            for (int s = 0; s < 2; s++) begin
                if (i_valid[s]) begin
                    e.rs     = i_phys_rs[s*PREG_W +: PREG_W];
                    e.rt     = i_phys_rt[s*PREG_W +: PREG_W];
                    e.usesRs = i_uses_rs[s];
                    e.usesRt = i_uses_rt[s];
                    e.rsRdy  = i_rs_ready[s] | (wb_valid & wb_uses_rw & i_uses_rs[s] & (e.rs == wb_tag));
                    e.rtRdy  = i_rt_ready[s] | (wb_valid & wb_uses_rw & i_uses_rt[s] & (e.rt == wb_tag));
                    e.al     = i_al_id[s*AL_W +: AL_W];
                    e.pay    = i_payload[s*PAY_W +: PAY_W];
                    mq.push_back(e);
                end
            end
        end
    endfunction

    function automatic void modelReset();
        mq.delete();
        statIssued = 0;
        statFull   = 0;
    endfunction

    task automatic clearInputs();
        i_valid = '0; i_phys_rs = '0; i_phys_rt = '0;
        i_uses_rs = '0; i_uses_rt = '0; i_rs_ready = '0; i_rt_ready = '0;
        i_al_id = '0; i_payload = '0;
        wb_valid = 1'b0; wb_uses_rw = 1'b0; wb_tag = '0;
        flush = 1'b0; i_issue_ready = 1'b0;
    endtask

    task automatic setSlot(input int s, input logic [PREG_W-1:0] rs, input logic [PREG_W-1:0] rt,
                           input logic ur, input logic ut, input logic rr, input logic rtr,
                           input logic [AL_W-1:0] al);
        i_valid[s]                  = 1'b1;
        i_phys_rs[s*PREG_W +: PREG_W] = rs;
        i_phys_rt[s*PREG_W +: PREG_W] = rt;
        i_uses_rs[s]                = ur;
        i_uses_rt[s]                = ut;
        i_rs_ready[s]               = rr;
        i_rt_ready[s]               = rtr;
        i_al_id[s*AL_W +: AL_W]     = al;
        i_payload[s*PAY_W +: PAY_W] = {$urandom, $urandom};
    endtask

    task automatic setReady(input int s, input logic [AL_W-1:0] al);
        setSlot(s, PREG_W'($urandom_range(0, 63)), PREG_W'($urandom_range(0, 63)),
                1'b1, 1'b1, 1'b1, 1'b1, al);
    endtask

    task automatic setBlocked(input int s, input logic [PREG_W-1:0] tag, input logic [AL_W-1:0] al);
        setSlot(s, tag, PREG_W'(0), 1'b1, 1'b0, 1'b0, 1'b0, al);
    endtask

    task automatic finishCycle();
        modelAdvance();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clearInputs();
        rst_n = 1'b0;
        modelReset();
        #3;
        compared++; if (o_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset.o_valid: got %0b expected 0", o_valid); end
        compared++; if (o_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset.o_ready: got %0b expected 1", o_ready); end
        compared++; if (dut.count_q !== '0) begin mismatched++; $display("[TB] FAIL reset.count: got %0d expected 0", dut.count_q); end
        compared++; if (o_al_id !== '0) begin mismatched++; $display("[TB] FAIL reset.o_al_id: got %0h expected 0", o_al_id); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_two_ready();
        clearInputs();
        setReady(0, 5'd3);
        setReady(1, 5'd4);
        i_issue_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            modelPredict();
            compared++; if (o_valid !== expValid) begin mismatched++; $display("[TB] FAIL twoReady.valid c%0d: got %0b expected %0b", k, o_valid, expValid); end
            compared++; if (o_al_id !== expAl) begin mismatched++; $display("[TB] FAIL twoReady.al c%0d: got %0d expected %0d", k, o_al_id, expAl); end
            compared++; if (o_al_id !== (k == 1 ? 5'd3 : k == 2 ? 5'd4 : 5'd0)) begin mismatched++; $display("[TB] FAIL twoReady.alConst c%0d: got %0d", k, o_al_id); end
            if (k == 3) begin
                compared++; if (dut.count_q !== '0) begin mismatched++; $display("[TB] FAIL twoReady.count: got %0d expected 0", dut.count_q); end
            end
            finishCycle();
            i_valid = 2'b00;
        end
    endtask

    task automatic test_wakeup();
        logic wantV [7];
        logic [AL_W-1:0] wantAl [7];
        wantV  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        wantAl = '{5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd8, 5'd0};
        for (int c = 0; c < 7; c++) begin
            clearInputs();
            i_issue_ready = 1'b1;
            if (c == 0) setBlocked(0, 6'd9, 5'd7);
            if (c == 2) begin wb_valid = 1'b1; wb_uses_rw = 1'b1; wb_tag = 6'd9; end
            if (c == 4) begin
                setBlocked(1, 6'd12, 5'd8);
                wb_valid = 1'b1; wb_uses_rw = 1'b1; wb_tag = 6'd12;
            end
            @(negedge clk);
            modelPredict();
            compared++; if (o_valid !== wantV[c]) begin mismatched++; $display("[TB] FAIL wakeup.valid c%0d: got %0b expected %0b", c, o_valid, wantV[c]); end
            compared++; if (o_al_id !== wantAl[c]) begin mismatched++; $display("[TB] FAIL wakeup.al c%0d: got %0d expected %0d", c, o_al_id, wantAl[c]); end
            compared++; if (o_phys_rs !== expRs) begin mismatched++; $display("[TB] FAIL wakeup.rs c%0d: got %0d expected %0d", c, o_phys_rs, expRs); end
            finishCycle();
        end
    endtask

    task automatic test_full();
        for (int c = 0; c < 5; c++) begin
            clearInputs();
            if (c < 3) begin
                setReady(0, 5'(10 + 2*c));
                setReady(1, 5'(11 + 2*c));
            end else if (c == 3) begin
                setReady(1, 5'd16);
            end else begin
                setReady(0, 5'd20);
                setReady(1, 5'd21);
            end
            @(negedge clk);
            modelPredict();
            compared++; if (o_ready !== expReady) begin mismatched++; $display("[TB] FAIL full.readyModel c%0d: got %0b expected %0b", c, o_ready, expReady); end
            compared++; if (o_ready !== 1'(c < 4)) begin mismatched++; $display("[TB] FAIL full.ready c%0d: got %0b expected %0b", c, o_ready, c < 4); end
            finishCycle();
        end
        compared++; if (dut.count_q !== 4'd7) begin mismatched++; $display("[TB] FAIL full.count: got %0d expected 7", dut.count_q); end
        clearInputs();
        i_issue_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            modelPredict();
            compared++; if (o_valid !== 1'(k < 7)) begin mismatched++; $display("[TB] FAIL full.drainValid k%0d: got %0b expected %0b", k, o_valid, k < 7); end
            compared++; if (o_al_id !== (k < 7 ? 5'(10 + k) : 5'd0)) begin mismatched++; $display("[TB] FAIL full.drainAl k%0d: got %0d expected %0d", k, o_al_id, k < 7 ? 10 + k : 0); end
            compared++; if (o_ready !== 1'(k != 0)) begin mismatched++; $display("[TB] FAIL full.drainReady k%0d: got %0b expected %0b", k, o_ready, k != 0); end
            compared++; if (32'(dut.count_q) !== mq.size()) begin mismatched++; $display("[TB] FAIL full.drainCount k%0d: got %0d expected %0d", k, dut.count_q, mq.size()); end
            finishCycle();
        end
    endtask

    task automatic test_collapse();
        logic wantV [8];
        logic [AL_W-1:0] wantAl [8];
        wantV  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        wantAl = '{5'd0, 5'd0, 5'd3, 5'd4, 5'd0, 5'd1, 5'd2, 5'd0};
        for (int c = 0; c < 8; c++) begin
            clearInputs();
            i_issue_ready = (c >= 2);
            if (c == 0) begin setBlocked(0, 6'd20, 5'd1); setBlocked(1, 6'd21, 5'd2); end
            if (c == 1) begin setReady(0, 5'd3); setReady(1, 5'd4); end
            if (c == 4) begin wb_valid = 1'b1; wb_uses_rw = 1'b1; wb_tag = 6'd20; end
            if (c == 5) begin wb_valid = 1'b1; wb_uses_rw = 1'b1; wb_tag = 6'd21; end
            @(negedge clk);
            modelPredict();
            compared++; if (o_valid !== wantV[c]) begin mismatched++; $display("[TB] FAIL collapse.valid c%0d: got %0b expected %0b", c, o_valid, wantV[c]); end
            compared++; if (o_al_id !== wantAl[c]) begin mismatched++; $display("[TB] FAIL collapse.al c%0d: got %0d expected %0d", c, o_al_id, wantAl[c]); end
            compared++; if (o_payload !== expPay) begin mismatched++; $display("[TB] FAIL collapse.payload c%0d: got %0h expected %0h", c, o_payload, expPay); end
            finishCycle();
        end
    endtask

    task automatic test_flush();
        logic [31:0] issuedBefore;
        issuedBefore = 0;
        for (int c = 0; c < 4; c++) begin
            clearInputs();
            i_issue_ready = 1'b1;
            if (c == 0) begin setReady(0, 5'd5); setReady(1, 5'd6); end
            if (c == 1) begin
                setReady(0, 5'd7); setReady(1, 5'd8);
                wb_valid = 1'b1; wb_uses_rw = 1'b1; wb_tag = 6'd3;
                flush = 1'b1;
            end
            @(negedge clk);
            modelPredict();
            if (c == 1) issuedBefore = statIssued;
            compared++; if (o_valid !== 1'(c == 1)) begin mismatched++; $display("[TB] FAIL flush.valid c%0d: got %0b expected %0b", c, o_valid, c == 1); end
            compared++; if (o_al_id !== expAl) begin mismatched++; $display("[TB] FAIL flush.al c%0d: got %0d expected %0d", c, o_al_id, expAl); end
            if (c >= 2) begin
                compared++; if (dut.count_q !== '0) begin mismatched++; $display("[TB] FAIL flush.count c%0d: got %0d expected 0", c, dut.count_q); end
                compared++; if (o_payload !== '0) begin mismatched++; $display("[TB] FAIL flush.payloadZero c%0d: got %0h expected 0", c, o_payload); end
`ifdef IQ_STATS_EN
                compared++; if (o_stat_issued !== issuedBefore) begin mismatched++; $display("[TB] FAIL flush.statIssued c%0d: got %0d expected %0d", c, o_stat_issued, issuedBefore); end
`endif
            end
            finishCycle();
        end
    endtask

    task automatic test_reset_mid();
        clearInputs();
        setReady(0, 5'd11);
        setReady(1, 5'd12);
        @(negedge clk);
        modelPredict();
        finishCycle();
        clearInputs();
        rst_n = 1'b0;
        #1;
        modelReset();
        compared++; if (o_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL resetMid.valid: got %0b expected 0", o_valid); end
        compared++; if (o_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL resetMid.ready: got %0b expected 1", o_ready); end
`ifdef IQ_STATS_EN
        compared++; if (o_stat_issued !== 32'd0) begin mismatched++; $display("[TB] FAIL resetMid.statIssued: got %0d expected 0", o_stat_issued); end
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        i_issue_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            modelPredict();
            compared++; if (o_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL resetMid.afterValid c%0d: got %0b expected 0", c, o_valid); end
            compared++; if (dut.count_q !== '0) begin mismatched++; $display("[TB] FAIL resetMid.count c%0d: got %0d expected 0", c, dut.count_q); end
            finishCycle();
        end
    endtask

    task automatic test_random();
        int alCounter;
        alCounter = 0;
        for (int c = 0; c < 500; c++) begin
            clearInputs();
            for (int s = 0; s < 2; s++) begin
                if ($urandom_range(0, 2) != 0) begin
                    setSlot(s, PREG_W'($urandom_range(0, 7)), PREG_W'($urandom_range(0, 7)),
                            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                            ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                            AL_W'(alCounter));
                    alCounter++;
                end
            end
            wb_valid      = 1'($urandom_range(0, 1));
            wb_uses_rw    = ($urandom_range(0, 3) != 0);
            wb_tag        = PREG_W'($urandom_range(0, 7));
            i_issue_ready = ($urandom_range(0, 3) != 0);
            flush         = ($urandom_range(0, 59) == 0);
            @(negedge clk);
            modelPredict();
            compared++; if (o_valid !== expValid) begin mismatched++; $display("[TB] FAIL rand.valid c%0d: got %0b expected %0b", c, o_valid, expValid); end
            compared++; if (o_ready !== expReady) begin mismatched++; $display("[TB] FAIL rand.ready c%0d: got %0b expected %0b", c, o_ready, expReady); end
            compared++; if (32'(dut.count_q) !== mq.size()) begin mismatched++; $display("[TB] FAIL rand.count c%0d: got %0d expected %0d", c, dut.count_q, mq.size()); end
            compared++; if ({o_phys_rs, o_phys_rt, o_al_id} !== {expRs, expRt, expAl}) begin mismatched++; $display("[TB] FAIL rand.fields c%0d: got %0h/%0h/%0h expected %0h/%0h/%0h", c, o_phys_rs, o_phys_rt, o_al_id, expRs, expRt, expAl); end
            compared++; if (o_payload !== expPay) begin mismatched++; $display("[TB] FAIL rand.payload c%0d: got %0h expected %0h", c, o_payload, expPay); end
`ifdef IQ_STATS_EN
            compared++; if (o_stat_issued !== statIssued) begin mismatched++; $display("[TB] FAIL rand.statIssued c%0d: got %0d expected %0d", c, o_stat_issued, statIssued); end
            compared++; if (o_stat_full !== statFull) begin mismatched++; $display("[TB] FAIL rand.statFull c%0d: got %0d expected %0d", c, o_stat_full, statFull); end
`endif
            finishCycle();
        end
        clearInputs();
    endtask

    initial begin
        test_reset();
        test_two_ready();
        test_wakeup();
        test_full();
        test_collapse();
        test_flush();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
